sram_like_arbiter: RTL
======================

Name: sram_like_arbiter

Overview:
- N-channel sram-like request arbiter that merges the core's sram-like master ports (inst, data, and future cache or uncached ports) onto one sram-like slave port.
- Tracks outstanding transactions in an in-order ID FIFO so that each slave data_ok is routed back to the channel that issued the request.
- Sits between the CPU top and the external sram-like-to-AXI bridge.

Parameters:
- NUM_CH, 2, number of master channels; channel 0 is highest priority in fixed mode.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- OUTST_DEPTH, 4, maximum outstanding accepted requests; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- m_req  in  NUM_CH  per-channel request
- m_wr  in  NUM_CH  per-channel write flag
- m_size  in  2*NUM_CH  per-channel size; 0 = byte, 1 = half, 2 = word
- m_addr  in  ADDR_W*NUM_CH  per-channel address, channel i in slice [i*ADDR_W +: ADDR_W]
- m_wdata  in  DATA_W*NUM_CH  per-channel write data
- m_addr_ok  out  NUM_CH  per-channel address accept
- m_data_ok  out  NUM_CH  per-channel data return
- m_rdata  out  DATA_W  read data, broadcast to all channels (equals s_rdata)
- s_req  out  1  slave request
- s_wr  out  1  slave write flag
- s_size  out  2  slave size
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_rdata  in  DATA_W  slave read data
- s_addr_ok  in  1  slave address accept
- s_data_ok  in  1  slave data return
- busy  out  1  high while count != 0 or state == LOCK
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (resetn low at clk edge):
  - state = IDLE, FIFO pointers and count = 0, rr_ptr = 0, lock_ch = 0, err = 0.
  - All outputs low, except the s_* payload, which mirrors the channel-0 inputs.
  - In-flight transactions are discarded; reset mid-operation needs no drain.
- full = (count == OUTST_DEPTH), taken from the registered count. No grant is issued while full, even if a pop occurs in the same cycle.
- State IDLE:
  - win = arbitration winner among the asserted m_req bits.
  - s_req = |m_req & ~full. The s_wr, s_size, s_addr and s_wdata outputs come combinationally from channel win.
  - If s_req & s_addr_ok: m_addr_ok[win] = 1 in the same cycle, push win into the FIFO, stay in IDLE.
  - If s_req & ~s_addr_ok: lock_ch <= win, go to LOCK.
- State LOCK:
  - The selection is frozen to lock_ch; s_req = m_req[lock_ch]. This satisfies the sram-like rule that the request stays stable until addr_ok.
  - On s_addr_ok: m_addr_ok[lock_ch] = 1, push lock_ch, go to IDLE.
  - If m_req[lock_ch] drops before addr_ok (a master protocol violation): set err, go to IDLE, push nothing.
- Return path:
  - m_data_ok[fifo_head] = s_data_ok when count != 0; pop on the same cycle.
  - m_rdata = s_rdata, combinational, no latency added.
  - s_data_ok while count == 0: ignored, no m_data_ok, err set.
- Push and pop in the same cycle: count unchanged and both pointers advance; pointers wrap modulo OUTST_DEPTH.
- Slave contract: data_ok for a request arrives no earlier than the cycle after its addr_ok.
- Latency: zero cycles added on both the address and data paths; one grant per cycle at most; ordering is strict in-order.
- The m_addr_ok and m_data_ok outputs are one-hot or zero.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- When defined: win = first asserted m_req at or after rr_ptr, searching cyclically. On each accepted grant (push), rr_ptr <= win+1 mod NUM_CH.
- When undefined: fixed priority, lowest asserted index wins; rr_ptr logic is absent.
- In both modes a LOCK is never preempted.

Test Plan:
- Single request, zero-wait slave, NUM_CH=2: m_req=01, s_addr_ok=1 in the same cycle -> m_addr_ok=01 that cycle; s_data_ok two cycles later with s_rdata=0xDEADBEEF -> m_data_ok=01, m_rdata=0xDEADBEEF.
- Lock hold: m_req=01, s_addr_ok held low for 3 cycles, m_req becomes 11 in cycle 2 -> s_addr stays ch0's 0x1000 for all cycles; on addr_ok, m_addr_ok=01; ch1 is granted the next cycle.
- Full back-pressure, OUTST_DEPTH=4: 4 accepted reads with no data_ok -> 5th cycle s_req=0, busy=1; one s_data_ok -> s_req=1 the following cycle.
- Ordering: grants ch1, ch0, ch1, then 3 s_data_ok pulses -> m_data_ok sequence 10, 01, 10.
- Arbitration with both requesting continuously for 4 grants: with ARB_ROUND_ROBIN_EN the grants are 0, 1, 0, 1; without it they are 0, 0, 0, 0.
- Error and reset: s_data_ok with count 0 -> err=1, m_data_ok=00. resetn low with 2 outstanding -> count=0, err=0, busy=0 the next cycle.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges NUM_CH sram-like master ports onto a single
// sram-like slave port. Accepted requests are tagged with their channel in an
// in-order ID FIFO so every slave data_ok is steered back to its issuer.
// Address and data paths add no latency; at most one grant per cycle.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise
// fixed priority (lowest channel index wins).
module sram_like_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTST_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        m_req,
  input  logic [NUM_CH-1:0]        m_wr,
  input  logic [2*NUM_CH-1:0]      m_size,
  input  logic [ADDR_W*NUM_CH-1:0] m_addr,
  input  logic [DATA_W*NUM_CH-1:0] m_wdata,
  output logic [NUM_CH-1:0]        m_addr_ok,
  output logic [NUM_CH-1:0]        m_data_ok,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     s_req,
  output logic                     s_wr,
  output logic [1:0]               s_size,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  input  logic [DATA_W-1:0]        s_rdata,
  input  logic                     s_addr_ok,
  input  logic                     s_data_ok,
  output logic                     busy,
  output logic                     err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(OUTST_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, LOCK} state_e;

  state_e           state_q;
  logic [CH_W-1:0]  lock_ch_q;
  logic             err_q;
  logic [CH_W-1:0]  fifo_q [OUTST_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CH_W-1:0]  win;
  logic [CH_W-1:0]  sel;
  logic             full;
  logic             push;
  logic             pop;
  logic             stray_dok;
  logic             req_drop;

`ifdef ARB_ROUND_ROBIN_EN
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;

  // Cyclic search for the first requester at or after rr_ptr.
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_CH;
      if (!found && m_req[idx]) begin
        win   = CH_W'(idx);
        found = 1'b1;
      end
    end
  end

  // Next search start is the channel after the one just granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push)
      rr_ptr_d = (int'(sel) == NUM_CH - 1) ? '0 : sel + 1'b1;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!resetn) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`else
  // Fixed priority: lowest asserted index wins; channel 0 when idle.
  always_comb begin
    win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m_req[i]) win = CH_W'(i);
  end
`endif

  // A pending LOCK freezes the selection so the request stays stable.
  assign sel  = (state_q == LOCK) ? lock_ch_q : win;
  assign full = (count_q == CNT_W'(OUTST_DEPTH));

  // Slave request: gated by reset and, when idle, by FIFO space.
  always_comb begin
    s_req = 1'b0;
    if (resetn) begin
      if (state_q == LOCK) s_req = m_req[lock_ch_q];
      else                 s_req = |m_req & ~full;
    end
  end

  assign push      = s_req & s_addr_ok;
  assign pop       = resetn & s_data_ok & (count_q != '0);
  assign stray_dok = s_data_ok & (count_q == '0);
  assign req_drop  = (state_q == LOCK) & ~m_req[lock_ch_q];

  assign s_wr    = m_wr[sel];
  assign s_size  = m_size[2*int'(sel) +: 2];
  assign s_addr  = m_addr[ADDR_W*int'(sel) +: ADDR_W];
  assign s_wdata = m_wdata[DATA_W*int'(sel) +: DATA_W];
  assign m_rdata = s_rdata;

  assign m_addr_ok = push ? (NUM_CH'(1) << sel) : '0;
  assign m_data_ok = pop  ? (NUM_CH'(1) << fifo_q[rd_ptr_q]) : '0;

  assign busy = (count_q != '0) | (state_q == LOCK);
  assign err  = err_q;

  // Arbitration FSM plus sticky protocol-error flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (s_req && !s_addr_ok) begin
          lock_ch_q <= win;
          state_q   <= LOCK;
        end
        LOCK: if (req_drop || s_addr_ok) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (req_drop || stray_dok) err_q <= 1'b1;
    end
  end

  // ID FIFO bookkeeping; pointers wrap naturally at the power-of-2 depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ID storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= sel;
  end

endmodule
